pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It drives the hold, bubble and flush controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) to resolve three conditions:

- load-use data hazards;
- taken-branch redirects;
- multi-cycle data-memory accesses.

It also freezes the core after a halt instruction retires and keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the 5-stage MIPS pipeline. Resolves load-use
//   hazards, taken-branch redirects and multi-cycle data-memory accesses by
//   driving hold/bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. Freezes the core after a halt retires and counts stall cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id_rs_addr/_rt_addr source registers of the ID instruction
//   id_uses_rs/_rt      ID instruction reads rs / rt
//   ex_load, ex_waddr   EX instruction is a load, and its destination
//   branch_taken_s3     EX resolved a taken branch/jump
//   mem_req_s4          MEM instruction accesses data memory
//   d_mem_ack           data memory completes the access this cycle
//   halt_s5             halt instruction in WB
//   hold_front          hold PC, IF/ID and ID/EX
//   bubble_ex           NOP into ID/EX (overrides the ID/EX hold)
//   flush_id            NOP into IF/ID
//   hold_mem            hold EX/MEM
//   bubble_wb           NOP into MEM/WB
//   halted              core frozen after halt
//   mem_timeout_err     sticky memory timeout
//   stall_cycles        saturating count of hold_front cycles
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_LEFT = 4,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_LEFT:0] id_rs_addr,
  input  logic [REG_ADDR_LEFT:0] id_rt_addr,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_load,
  input  logic [REG_ADDR_LEFT:0] ex_waddr,
  input  logic                   branch_taken_s3,
  input  logic                   mem_req_s4,
  input  logic                   d_mem_ack,
  input  logic                   halt_s5,
  output logic                   hold_front,
  output logic                   bubble_ex,
  output logic                   flush_id,
  output logic                   hold_mem,
  output logic                   bubble_wb,
  output logic                   halted,
  output logic                   mem_timeout_err,
  output logic [31:0]            stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       load_use, mem_busy;

  assign load_use = ex_load && (ex_waddr != '0) &&
                    ((id_uses_rs && (id_rs_addr == ex_waddr)) ||
                     (id_uses_rt && (id_rt_addr == ex_waddr)));
  assign mem_busy = mem_req_s4 && !d_mem_ack;

  always_comb begin
    hold_front   = 1'b0;
    bubble_ex    = 1'b0;
    flush_id     = 1'b0;
    hold_mem     = 1'b0;
    bubble_wb    = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            hold_front   = 1'b1;
            hold_mem     = 1'b1;
            bubble_wb    = 1'b1;
            wait_cnt_nxt = 8'd1;
            // The request cycle is itself the first wait cycle, so a
            // one-cycle budget is already exhausted here.
            state_nxt    = (TIMEOUT == 8'd1) ? ERROR : MEM_WAIT;
          end else if (branch_taken_s3) begin
            // ID holds a wrong-path instruction: any load-use is moot.
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (load_use) begin
            hold_front = 1'b1;
            bubble_ex  = 1'b1;
          end
          if (halt_s5) state_nxt = HALTED;
        end
        MEM_WAIT: begin
          if (d_mem_ack) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
            // EX was frozen during the wait, so its branch/load-use
            // condition is resolved now.
            if (branch_taken_s3) begin
              flush_id  = 1'b1;
              bubble_ex = 1'b1;
            end else if (load_use) begin
              hold_front = 1'b1;
              bubble_ex  = 1'b1;
            end
          end else begin
            hold_front   = 1'b1;
            hold_mem     = 1'b1;
            bubble_wb    = 1'b1;
            wait_cnt_nxt = wait_cnt + 8'd1;
            if (wait_cnt_nxt == TIMEOUT) state_nxt = ERROR;
          end
        end
        HALTED, ERROR: begin
          hold_front = 1'b1;
          hold_mem   = 1'b1;
          bubble_wb  = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (hold_front && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign halted          = (state == HALTED);
  assign mem_timeout_err = (state == ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table-driven single-cycle hazard vectors in
// RUN plus hand-written multi-cycle sequences (memory wait, timeout, halt,
// reset, counter saturation). Expectations are queued when inputs are driven
// and checked on the following negative edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, ex_waddr = '0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_load = 1'b0;
  logic        branch_taken_s3 = 1'b0, mem_req_s4 = 1'b0, d_mem_ack = 1'b0;
  logic        halt_s5 = 1'b0;
  logic        hold_front, bubble_ex, flush_id, hold_mem, bubble_wb;
  logic        halted, mem_timeout_err;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_LEFT(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_load(ex_load), .ex_waddr(ex_waddr),
    .branch_taken_s3(branch_taken_s3), .mem_req_s4(mem_req_s4),
    .d_mem_ack(d_mem_ack), .halt_s5(halt_s5),
    .hold_front(hold_front), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .hold_mem(hold_mem), .bubble_wb(bubble_wb),
    .halted(halted), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles)
  );

  // ctl bit order: {hold_front, bubble_ex, flush_id, hold_mem, bubble_wb}
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] HOLDS = 5'b10011;
  localparam logic [4:0] LU    = 5'b11000;
  localparam logic [4:0] BR    = 5'b01100;

  typedef struct {
    int         tag;
    logic [4:0] rs, rt;
    logic       urs, urt, ld;
    logic [4:0] wa;
    logic       br, mreq, ack, halt;
    logic [4:0] ctl;
    logic       hlt, err;
  } vec_t;

  typedef struct {
    int          tag;
    logic [4:0]  ctl;
    logic        chk;
    logic        hlt, err;
    logic [31:0] stall;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_stall = '0;
  vec_t        tbl[10];

  function automatic vec_t mk(int tag, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic ld, logic [4:0] wa,
                              logic br, logic mreq, logic ack, logic halt,
                              logic [4:0] ctl, logic hlt, logic err);
    vec_t v;
    v.tag = tag; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.ld = ld;
    v.wa = wa; v.br = br; v.mreq = mreq; v.ack = ack; v.halt = halt;
    v.ctl = ctl; v.hlt = hlt; v.err = err;
    return v;
  endfunction

  function automatic vec_t mks(int tag, logic br, logic mreq, logic ack,
                               logic halt, logic [4:0] ctl, logic hlt,
                               logic err);
    return mk(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, br, mreq, ack, halt,
              ctl, hlt, err);
  endfunction

  task automatic drive(input vec_t v, input logic r);
    rst = r;
    id_rs_addr = v.rs; id_rt_addr = v.rt;
    id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_load = v.ld; ex_waddr = v.wa;
    branch_taken_s3 = v.br; mem_req_s4 = v.mreq; d_mem_ack = v.ack;
    halt_s5 = v.halt;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    drive(v, 1'b0);
    e.tag = v.tag; e.ctl = v.ctl; e.chk = 1'b1;
    e.hlt = v.hlt; e.err = v.err; e.stall = model_stall;
    sb.push_back(e);
    if (v.ctl[4] && (model_stall != 32'hFFFF_FFFF))
      model_stall = model_stall + 32'd1;
  endtask

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    apply(v);
  endtask

  // Reset cycle with hazard-provoking inputs: controls must still be 0.
  task automatic do_reset(input int tag);
    exp_t e;
    @(posedge clk); #1;
    drive(mk(tag, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0,
             1'b1, NONE, 1'b0, 1'b0), 1'b1);
    e.tag = tag; e.ctl = NONE; e.chk = 1'b0;
    e.hlt = 1'b0; e.err = 1'b0; e.stall = '0;
    sb.push_back(e);
    model_stall = '0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({hold_front, bubble_ex, flush_id, hold_mem, bubble_wb} !== e.ctl) begin
        failures++;
        $display("FAIL ctl tag=%0d got=%b exp=%b", e.tag,
                 {hold_front, bubble_ex, flush_id, hold_mem, bubble_wb}, e.ctl);
      end
      if (e.chk) begin
        checks++;
        if ({halted, mem_timeout_err, stall_cycles} !== {e.hlt, e.err, e.stall}) begin
          failures++;
          $display("FAIL regs tag=%0d got halted=%b err=%b stall=%h exp halted=%b err=%b stall=%h",
                   e.tag, halted, mem_timeout_err, stall_cycles, e.hlt, e.err, e.stall);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            tag rs    rt    urs  urt  ld   wa    br   mreq ack  halt ctl
    tbl[0] = mk(0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    tbl[1] = mk(1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, 1'b0);
    tbl[2] = mk(2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    tbl[3] = mk(3, 5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, 1'b0);
    tbl[4] = mk(4, 5'd7, 5'd1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    tbl[5] = mk(5, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    tbl[6] = mk(6, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, BR,   1'b0, 1'b0);
    tbl[7] = mk(7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, BR,   1'b0, 1'b0);
    tbl[8] = mk(8, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, LU,   1'b0, 1'b0);
    tbl[9] = mk(9, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0);

    do_reset(99);
    step(mks(100, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) step(tbl[i]);

    // Memory access acked after 3 wait cycles.
    step(mks(200, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mks(201, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mks(202, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mks(203, 1'b0, 1'b1, 1'b1, 1'b0, NONE,  1'b0, 1'b0));
    step(mks(204, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, 1'b0));
    // Ack cycle re-evaluates branch and load-use.
    step(mks(205, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mks(206, 1'b1, 1'b1, 1'b1, 1'b0, BR,    1'b0, 1'b0));
    step(mks(207, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, 1'b0));
    step(mks(208, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mk(209, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, LU, 1'b0, 1'b0));
    step(mks(210, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  1'b0, 1'b0));

    // Ack on exactly the MEM_TIMEOUT-th wait cycle: no error.
    for (int i = 0; i < 3; i++)
      step(mks(220 + i, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mks(223, 1'b0, 1'b1, 1'b1, 1'b0, NONE, 1'b0, 1'b0));
    step(mks(224, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0));

    // Timeout after 4 non-acked wait cycles; error is sticky.
    for (int i = 0; i < 4; i++)
      step(mks(230 + i, 1'b0, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b0));
    step(mks(234, 1'b1, 1'b1, 1'b0, 1'b0, HOLDS, 1'b0, 1'b1));
    step(mk(235, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, HOLDS, 1'b0, 1'b1));
    do_reset(240);
    step(mks(241, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0));

    // Halt, holds persist, then counter saturation while frozen.
    step(mks(250, 1'b0, 1'b0, 1'b0, 1'b1, NONE, 1'b0, 1'b0));
    step(mk(251, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, HOLDS, 1'b1, 1'b0));
    step(mks(252, 1'b0, 1'b1, 1'b0, 1'b1, HOLDS, 1'b1, 1'b0));
    @(posedge clk); #1;
    force dut.stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles;
    model_stall = 32'hFFFF_FFFD;
    apply(mks(253, 1'b0, 1'b0, 1'b0, 1'b0, HOLDS, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      step(mks(254 + i, 1'b0, 1'b0, 1'b1, 1'b0, HOLDS, 1'b1, 1'b0));
    do_reset(259);
    step(mks(260, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0));

    // Halt together with a memory stall: stall outputs now, HALTED next.
    step(mks(270, 1'b0, 1'b1, 1'b0, 1'b1, HOLDS, 1'b0, 1'b0));
    step(mks(271, 1'b0, 1'b1, 1'b1, 1'b0, HOLDS, 1'b1, 1'b0));
    do_reset(272);
    step(mks(273, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0));

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
